seq_detect_onehot: RTL
======================

// Module: seq_detect_onehot
// PURPOSE
//  Parametrised Moore sequence detector with a one-hot state register.
//  - Recognises a run-time loadable pattern of DEPTH symbols, each IN_W bits wide.
//  - Successor to the fixed 4-state, 2-bit-input one-hot FSMs used in the HW blocks.
//  - Adds a loadable pattern, a sticky/restart match mode and defined illegal-state recovery.
// PARAMETERS
//  IN_W        2        symbol width (bits)
//  DEPTH       4        pattern length in symbols, >=2; state width is DEPTH+1
//  PATTERN_RST 8'hB4    pattern at reset (DEPTH*IN_W bits); sym[k] = pattern[k*IN_W +: IN_W]
//  CNT_W       8        match counter width (used only with SEQDET_MATCH_COUNT_EN)
// PORTS
//  clock      in   1           system clock, rising edge
//  init       in   1           asynchronous active-low reset
//  in         in   IN_W        input symbol, one symbol per clock
//  load       in   1           sample pattern_in; restart the FSM
//  pattern_in in   DEPTH*IN_W  new pattern; sym[0] in the LSBs
//  sticky     in   1           1: DONE holds until clr; 0: restart after DONE
//  clr        in   1           leave DONE (sticky mode); ignored otherwise
//  out        out  1           1 while in DONE (Moore)
//  state      out  DEPTH+1     one-hot state; bit k = k symbols matched, bit DEPTH = DONE
//  match_cnt  out  CNT_W       saturating match count (0 unless macro defined)
// BEHAVIOUR
//  - Reset (init=0, async): state=1 (S0), pattern register=PATTERN_RST, out=0, match_cnt=0.
//  - Priority, highest first: reset, load, illegal state, normal transition.
//  - load=1: pattern register <= pattern_in; state <= S0 next edge; in is ignored that cycle.
//  - Illegal state (zero or >1 bits set): next state S0; out = state[DEPTH] as is. Never X.
//  - Sk, k<DEPTH:
//    - in==sym[k] -> S(k+1).
//    - otherwise -> S1 if in==sym[0], else S0. This fallback is a simple rule, not KMP.
//  - DONE, sticky=1: stay in DONE until clr=1; then take the S0 transition on that cycle's in.
//  - DONE, sticky=0: take the S0 transition on the current in.
//  - out = state[DEPTH], registered. Asserts 1 cycle after the last matching symbol is sampled.
//  - Latency: first symbol sampled in S0 -> out=1 exactly DEPTH edges later.
//  - Simultaneous load and clr: load wins.
//  - Changing sticky mid-sequence: takes effect on the next edge only.
//  - A reset mid-sequence aborts immediately; no partial match is retained.
// CONFIGURATION
//  SEQDET_MATCH_COUNT_EN defined:
//    - match_cnt increments on every entry into DONE from S(DEPTH-1).
//    - Saturates at 2^CNT_W-1; cleared by reset and by load.
//    - Staying in DONE under sticky=1 does not increment it.
//  Not defined: match_cnt is tied to 0; no counter flops are synthesised.
// STRUCTURE
//  - Package seq_detect_pkg:
//    - localparams S0_IDX=0 and DONE_IDX=DEPTH;
//    - function onehot_ok(state), true iff exactly one bit is set;
//    - function sym(pattern,k), extracts symbol k.
//  - Sub-module onehot_state_reg: DEPTH+1 flops.
//    - Bit 0 is set on reset; the others are cleared on reset.
//    - Async active-low init, same convention as the existing set/reset DFF.
//  - Next-state logic is a generate loop over k.
//  - Expected size: about 150-250 lines.
// TESTING  (IN_W=2, DEPTH=4, pattern sym0..3 = 00,01,11,10 i.e. 8'hB4)
//  1. Reset then in=00,01,11,10 -> state 00001,00010,00100,01000,10000; out=1 on the 4th edge.
//  2. sticky=1, DONE, in=00 for 3 cycles, then clr=1 with in=00 -> holds DONE 3 cycles, then S1.
//  3. sticky=0, stream 00,01,11,10,00,01,11,10 -> out high for one cycle, twice; match_cnt=2 (macro on).
//  4. In S3, in=00 -> S1; in S2, in=10 -> S0 (fallback rule).
//  5. load=1 with pattern_in=8'h1B while in S3 -> S0 next edge, match_cnt=0; then 11,10,01,00 -> DONE.
//  6. Force state=00110 -> S0 next edge. init=0 mid-sequence -> state=00001 with no clock.
//  7. Macro on, CNT_W=2, 5 matches -> match_cnt sticks at 3. Macro off -> match_cnt stays 0.

Source files
------------

// File: rtl/seq_detect_onehot_pkg.sv
// Shared helpers for the one-hot sequence detector: state index constants,
// one-hot legality check and pattern symbol extraction.
package seq_detect_pkg;

  localparam int S0_IDX      = 0;
  localparam int MAX_STATE_W = 64;
  localparam int MAX_IN_W    = 16;
  localparam int MAX_PAT_W   = 512;

  function automatic logic onehot_ok(input logic [MAX_STATE_W-1:0] s);
    return ($countones(s) == 1);
  endfunction

  // Callers zero-extend their pattern; the result is masked to in_w bits.
  function automatic logic [MAX_IN_W-1:0] sym(input logic [MAX_PAT_W-1:0] pattern,
                                              input int k, input int in_w);
    logic [MAX_PAT_W-1:0] shifted;
    logic [MAX_IN_W-1:0]  mask;
    shifted = pattern >> (k * in_w);
    mask    = MAX_IN_W'((1 << in_w) - 1);
    return shifted[MAX_IN_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/seq_detect_onehot_if.sv
// Symbol/control/status bundle of the sequence detector; slave side is the detector.
interface seq_detect_onehot_if #(
  parameter int IN_W  = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  logic [IN_W-1:0]       in;
  logic                  load;
  logic [DEPTH*IN_W-1:0] pattern_in;
  logic                  sticky;
  logic                  clr;
  logic                  out;
  logic [DEPTH:0]        state;
  logic [CNT_W-1:0]      match_cnt;

  modport master (output in, load, pattern_in, sticky, clr,
                  input  out, state, match_cnt);
  modport slave  (input  in, load, pattern_in, sticky, clr,
                  output out, state, match_cnt);
endinterface

// File: rtl/seq_detect_onehot_state_reg.sv
// One-hot state flops: bit S0_IDX comes out of reset set, all others clear.
module onehot_state_reg
  import seq_detect_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clock,
  input  logic         init,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clock or negedge init) begin
    if (!init) r_q <= W'(1) << S0_IDX;
    else       r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/seq_detect_onehot.sv
// Moore detector for a loadable DEPTH-symbol pattern with one-hot state.
// Define SEQDET_MATCH_COUNT_EN to build the saturating match counter.
module seq_detect_onehot
  import seq_detect_pkg::*;
#(
  parameter int                      IN_W        = 2,
  parameter int                      DEPTH       = 4,
  parameter logic [DEPTH*IN_W-1:0]   PATTERN_RST = 8'hB4,
  parameter int                      CNT_W       = 8
) (
  input logic                clock,
  input logic                init,
  seq_detect_onehot_if.slave bus
);

  localparam int              SW        = DEPTH + 1;
  localparam int              DONE_IDX  = DEPTH;
  localparam int              PAT_W     = DEPTH * IN_W;
  localparam logic [SW-1:0]   S0_ONEHOT = SW'(1) << S0_IDX;

  logic [PAT_W-1:0] r_pattern;
  logic [SW-1:0]    w_state;
  logic [SW-1:0]    w_calc;
  logic [SW-1:0]    w_next;
  logic [DEPTH-1:0] w_match;
  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_miss;
  logic             w_legal;
  logic             w_done_hold;
  logic             w_restart;

  always_ff @(posedge clock or negedge init) begin
    if (!init)         r_pattern <= PATTERN_RST;
    else if (bus.load) r_pattern <= bus.pattern_in;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_sym
    logic [MAX_IN_W-1:0] w_sym;
    assign w_sym      = sym(MAX_PAT_W'(r_pattern), k, IN_W);
    assign w_match[k] = (w_sym == MAX_IN_W'(bus.in));
    assign w_adv[k]   = w_state[k] & w_match[k];
    assign w_miss[k]  = w_state[k] & ~w_match[k];
    if (k >= 2) begin : g_mid
      assign w_calc[k] = w_adv[k-1];
    end
  end

  // A miss in any partial state, or leaving DONE, restarts from S0 on this symbol.
  assign w_legal     = onehot_ok(MAX_STATE_W'(w_state));
  assign w_done_hold = w_state[DONE_IDX] & bus.sticky & ~bus.clr;
  assign w_restart   = (w_state[DONE_IDX] & ~w_done_hold) | (|w_miss);

  assign w_calc[0]        = w_restart & ~w_match[0];
  assign w_calc[1]        = w_adv[0] | (w_restart & w_match[0]);
  assign w_calc[DONE_IDX] = w_adv[DEPTH-1] | w_done_hold;

  always_comb begin
    w_next = w_calc;
    if (bus.load)     w_next = S0_ONEHOT;
    else if (!w_legal) w_next = S0_ONEHOT;
  end

  onehot_state_reg #(.W(SW)) u_state_reg (
    .clock (clock),
    .init  (init),
    .i_d   (w_next),
    .o_q   (w_state)
  );

  assign bus.state = w_state;
  assign bus.out   = w_state[DONE_IDX];

`ifdef SEQDET_MATCH_COUNT_EN
  logic [CNT_W-1:0] r_match_cnt;
  logic             w_enter_done;

  assign w_enter_done = ~bus.load & w_legal & w_adv[DEPTH-1];

  always_ff @(posedge clock or negedge init) begin
    if (!init)                                  r_match_cnt <= '0;
    else if (bus.load)                          r_match_cnt <= '0;
    else if (w_enter_done && (r_match_cnt != '1)) r_match_cnt <= r_match_cnt + 1'b1;
  end

  assign bus.match_cnt = r_match_cnt;
`else
  assign bus.match_cnt = '0;
`endif

endmodule
